// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - state encoding, default pattern and parity helper for the serial pattern transmitter
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } seq_tx_state_t;

    localparam logic [3:0] SEQ_TX_DEFAULT_PAT = 4'b1011;
    localparam int         SEQ_TX_MAX_W       = 16;

    // Even parity; callers zero-extend narrower patterns, which leaves the result unchanged.
    function automatic logic seq_tx_parity(input logic [SEQ_TX_MAX_W-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// rtl/seq_tx_shreg.sv - parallel-load MSB-first shift register with bit index and last-bit flag
module seq_tx_shreg
    import seq_tx_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_data,
    output logic         bit_out,
    output logic         last_bit
);

    localparam int               IDX_W   = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(W - 1);

    logic [W-1:0]     sr_q;
    logic [IDX_W-1:0] idx_q;

    // Shifting zeros in means the output bit falls to 0 once a frame is fully sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else if (load) begin
            sr_q  <= load_data;
            idx_q <= IDX_TOP;
        end else if (shift) begin
            sr_q  <= {sr_q[W-2:0], 1'b0};
            idx_q <= idx_q - IDX_W'(1);
        end
    end

    assign bit_out  = sr_q[W-1];
    assign last_bit = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter top; SEQ_PATTERN_TX_PARITY_EN appends an even-parity bit per frame
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(SEQ_TX_DEFAULT_PAT),
    parameter int               GAP_CYC     = 1,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] start_pattern,
    input  logic [CNT_W-1:0] start_frames,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int FRAME_W = PAT_W + 1;
`else
    localparam int FRAME_W = PAT_W;
`endif
    localparam int               GAP_W    = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    function automatic logic [FRAME_W-1:0] frame_word(input logic [PAT_W-1:0] pat);
`ifdef SEQ_PATTERN_TX_PARITY_EN
        return {pat, seq_tx_parity(SEQ_TX_MAX_W'(pat))};
`else
        return pat;
`endif
    endfunction

    seq_tx_state_t      state_q, state_nxt;
    logic [CNT_W-1:0]   frames_q, frames_nxt;
    logic [GAP_W-1:0]   gap_q, gap_nxt;
    logic [FRAME_W-1:0] word_q, word_nxt;
    logic [FRAME_W-1:0] sr_data;
    logic [PAT_W-1:0]   sel_pat;
    logic               sr_load, sr_shift, last_bit, bit_out, accept;
    logic               start_ready_q, dout_valid_q, busy_q, done_q;

    assign sel_pat = (start_pattern == '0) ? DEFAULT_PAT : start_pattern;
    assign accept  = start_valid && start_ready_q;

    seq_tx_shreg #(.W(FRAME_W)) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (sr_data),
        .bit_out   (bit_out),
        .last_bit  (last_bit)
    );

    always_comb begin
        state_nxt  = state_q;
        frames_nxt = frames_q;
        gap_nxt    = gap_q;
        word_nxt   = word_q;
        sr_data    = word_q;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_nxt   = frame_word(sel_pat);
                    sr_data    = frame_word(sel_pat);
                    sr_load    = 1'b1;
                    frames_nxt = (start_frames == '0) ? ONE : start_frames;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                // The last bit still shifts so the register drains to zero for GAP/DONE.
                if (!last_bit) begin
                    sr_shift = 1'b1;
                end else if (frames_q <= ONE) begin
                    sr_shift  = 1'b1;
                    state_nxt = DONE;
                end else if (GAP_CYC == 0) begin
                    sr_load    = 1'b1;
                    frames_nxt = frames_q - ONE;
                end else begin
                    sr_shift  = 1'b1;
                    gap_nxt   = GAP_LOAD;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    sr_load    = 1'b1;
                    frames_nxt = frames_q - ONE;
                    state_nxt  = SHIFT;
                end else begin
                    gap_nxt = gap_q - GAP_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            frames_q      <= '0;
            gap_q         <= '0;
            word_q        <= '0;
            start_ready_q <= 1'b0;
            dout_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            frames_q      <= frames_nxt;
            gap_q         <= gap_nxt;
            word_q        <= word_nxt;
            start_ready_q <= (state_nxt == IDLE);
            dout_valid_q  <= (state_nxt == SHIFT);
            busy_q        <= (state_nxt != IDLE);
            done_q        <= (state_nxt == DONE);
        end
    end

    assign start_ready = start_ready_q;
    assign dout        = bit_out;
    assign dout_valid  = dout_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - scoreboard bench for seq_pattern_tx with back-to-back and gapped instances
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int FL = PAT_W + 1;
`else
    localparam int FL = PAT_W;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sv_a = 1'b0, sv_b = 1'b0;
    logic [PAT_W-1:0] sp_a = '0, sp_b = '0;
    logic [CNT_W-1:0] sf_a = '0, sf_b = '0;
    logic             rdy_a, dout_a, dv_a, busy_a, done_a;
    logic             rdy_b, dout_b, dv_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit qa[$];
    bit qb[$];

    always #5 clk = ~clk;

    seq_pattern_tx #(.PAT_W(PAT_W), .GAP_CYC(0), .CNT_W(CNT_W)) u_dut_a (
        .clk(clk), .rst(rst), .start_valid(sv_a), .start_ready(rdy_a),
        .start_pattern(sp_a), .start_frames(sf_a), .dout(dout_a),
        .dout_valid(dv_a), .busy(busy_a), .done(done_a)
    );

    seq_pattern_tx #(.PAT_W(PAT_W), .GAP_CYC(2), .CNT_W(CNT_W)) u_dut_b (
        .clk(clk), .rst(rst), .start_valid(sv_b), .start_ready(rdy_b),
        .start_pattern(sp_b), .start_frames(sf_b), .dout(dout_b),
        .dout_valid(dv_b), .busy(busy_b), .done(done_b)
    );

    task automatic push_exp(input bit which, input logic [PAT_W-1:0] pat, input int frames);
        logic [PAT_W-1:0] p;
        int n;
        p = (pat == '0) ? 4'b1011 : pat;
        n = (frames == 0) ? 1 : frames;
        for (int f = 0; f < n; f++) begin
            for (int i = PAT_W - 1; i >= 0; i--) begin
                if (which) qb.push_back(p[i]); else qa.push_back(p[i]);
            end
`ifdef SEQ_PATTERN_TX_PARITY_EN
            if (which) qb.push_back(^p); else qa.push_back(^p);
`endif
        end
    endtask

    // Returns at the sampling point of cycle T+1 with inputs scrambled.
    task automatic send_a(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] frames);
        @(negedge clk);
        sv_a = 1'b1; sp_a = pat; sf_a = frames;
        push_exp(1'b0, pat, int'(frames));
        @(negedge clk);
        sv_a = 1'b0; sp_a = 4'b0110; sf_a = 8'd7;
    endtask

    task automatic send_b(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] frames);
        @(negedge clk);
        sv_b = 1'b1; sp_b = pat; sf_b = frames;
        push_exp(1'b1, pat, int'(frames));
        @(negedge clk);
        sv_b = 1'b0; sp_b = 4'b0110; sf_b = 8'd7;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if (rdy_a !== 1'b0 || dv_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold got rdy=%b dv=%b done=%b busy=%b exp 0 0 0 0", rdy_a, dv_a, done_a, busy_a);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || dv_a !== 1'b0 || done_a !== 1'b0 || dout_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got rdy_a=%b rdy_b=%b dv=%b done=%b dout=%b exp 1 1 0 0 0",
                     rdy_a, rdy_b, dv_a, done_a, dout_a);
        end
    endtask

    task automatic test_single;
        int nv = 0;
        int nd = 0;
        bit eb;
        send_a(4'b1011, 8'd1);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 2) begin sv_a = 1'b1; sp_a = 4'b1111; sf_a = 8'd1; end
            if (c == 4) sv_a = 1'b0;
            if (dv_a) begin
                nv++;
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++; $display("FAIL single_extra_bit cycle %0d got unexpected valid bit", c);
                end else begin
                    eb = qa.pop_front();
                    if (dout_a !== eb || c != nv) begin
                        n_fail++; $display("FAIL single_bit cycle %0d got %b exp %b (valid index %0d)", c, dout_a, eb, nv);
                    end
                end
            end
            if (done_a) begin
                nd++;
                n_checks++;
                if (c != FL + 1) begin
                    n_fail++; $display("FAIL single_done_cycle got %0d exp %0d", c, FL + 1);
                end
            end
            if (c == FL + 1 || c == FL + 2) begin
                n_checks++;
                if (rdy_a !== (c == FL + 2)) begin
                    n_fail++; $display("FAIL single_ready cycle %0d got %b exp %b", c, rdy_a, (c == FL + 2));
                end
            end
        end
        n_checks++;
        if (nv != FL || nd != 1) begin
            n_fail++; $display("FAIL single_counts got valid=%0d done=%0d exp %0d 1", nv, nd, FL);
        end
    endtask

    task automatic test_back_to_back;
        int nv = 0, nd = 0, first = 0, last = 0, det = 0;
        logic [3:0] hist = '0;
        bit eb;
        send_a(4'b1011, 8'd3);
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (dv_a) begin
                nv++;
                if (first == 0) first = c;
                last = c;
                hist = {hist[2:0], dout_a};
                if (nv >= 4 && hist == 4'b1011) det++;
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_bit cycle %0d", c);
                end else begin
                    eb = qa.pop_front();
                    if (dout_a !== eb) begin
                        n_fail++; $display("FAIL b2b_bit cycle %0d got %b exp %b", c, dout_a, eb);
                    end
                end
            end
            if (done_a) nd++;
        end
        n_checks++;
        if (nv != 3 * FL || first != 1 || last - first + 1 != nv) begin
            n_fail++; $display("FAIL b2b_contiguous got valid=%0d first=%0d last=%0d exp %0d 1 %0d", nv, first, last, 3 * FL, 3 * FL);
        end
        n_checks++;
        if (det != 3 || nd != 1) begin
            n_fail++; $display("FAIL b2b_detector got hits=%0d done=%0d exp 3 1", det, nd);
        end
    endtask

    task automatic test_default_gap;
        int nv = 0, nd = 0, prev = 0, ngaps = 0, gaplen = 0, done_c = 0;
        bit eb;
        send_b(4'b0000, 8'd0);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (dv_b) begin
                nv++;
                n_checks++;
                if (qb.size() == 0) begin
                    n_fail++; $display("FAIL default_extra_bit cycle %0d", c);
                end else begin
                    eb = qb.pop_front();
                    if (dout_b !== eb) begin
                        n_fail++; $display("FAIL default_bit cycle %0d got %b exp %b", c, dout_b, eb);
                    end
                end
            end
            if (done_b) nd++;
        end
        n_checks++;
        if (nv != FL || nd != 1) begin
            n_fail++; $display("FAIL default_counts got valid=%0d done=%0d exp %0d 1", nv, nd, FL);
        end
        nv = 0; nd = 0;
        send_b(4'b0000, 8'd2);
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (dv_b) begin
                nv++;
                if (prev > 0 && c - prev - 1 != 0) begin ngaps++; gaplen = c - prev - 1; end
                prev = c;
                n_checks++;
                if (qb.size() == 0) begin
                    n_fail++; $display("FAIL gap_extra_bit cycle %0d", c);
                end else begin
                    eb = qb.pop_front();
                    if (dout_b !== eb) begin
                        n_fail++; $display("FAIL gap_bit cycle %0d got %b exp %b", c, dout_b, eb);
                    end
                end
            end else if (busy_b && dout_b !== 1'b0) begin
                n_checks++; n_fail++;
                $display("FAIL gap_dout_idle cycle %0d got %b exp 0", c, dout_b);
            end
            if (done_b) begin nd++; done_c = c; end
        end
        n_checks++;
        if (ngaps != 1 || gaplen != 2 || nv != 2 * FL) begin
            n_fail++; $display("FAIL gap_shape got gaps=%0d len=%0d valid=%0d exp 1 2 %0d", ngaps, gaplen, nv, 2 * FL);
        end
        n_checks++;
        if (nd != 1 || done_c != 2 * FL + 3) begin
            n_fail++; $display("FAIL gap_done got count=%0d cycle=%0d exp 1 %0d", nd, done_c, 2 * FL + 3);
        end
    endtask

    task automatic test_rst_and_valid;
        @(negedge clk);
        rst = 1'b1; sv_a = 1'b1; sp_a = 4'b1011; sf_a = 8'd1;
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || dv_a !== 1'b0 || rdy_a !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid_hold got busy=%b dv=%b rdy=%b exp 0 0 0", busy_a, dv_a, rdy_a);
        end
        rst = 1'b0; sv_a = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || dv_a !== 1'b0 || rdy_a !== 1'b1) begin
            n_fail++; $display("FAIL rst_valid_after got busy=%b dv=%b rdy=%b exp 0 0 1", busy_a, dv_a, rdy_a);
        end
    endtask

    task automatic test_midframe_reset;
        int nv = 0, nd = 0;
        bit eb;
        send_a(4'b1011, 8'd2);
        for (int c = 1; c <= 2; c++) begin
            if (c > 1) @(negedge clk);
            eb = qa.pop_front();
            n_checks++;
            if (dv_a !== 1'b1 || dout_a !== eb) begin
                n_fail++; $display("FAIL midrst_bit cycle %0d got dv=%b dout=%b exp 1 %b", c, dv_a, dout_a, eb);
            end
        end
        rst = 1'b1;
        qa.delete();
        @(negedge clk);
        n_checks++;
        if (dv_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || dout_a !== 1'b0 || rdy_a !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle got dv=%b busy=%b done=%b dout=%b rdy=%b exp 0 0 0 0 0",
                               dv_a, busy_a, done_a, dout_a, rdy_a);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (done_a !== 1'b0 || dv_a !== 1'b0) begin
                n_fail++; $display("FAIL midrst_quiet cycle %0d got done=%b dv=%b exp 0 0", c, done_a, dv_a);
            end
        end
        send_a(4'b1011, 8'd1);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            if (dv_a) begin
                nv++;
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++; $display("FAIL midrst_extra_bit cycle %0d", c);
                end else begin
                    eb = qa.pop_front();
                    if (dout_a !== eb) begin
                        n_fail++; $display("FAIL midrst_fresh_bit cycle %0d got %b exp %b", c, dout_a, eb);
                    end
                end
            end
            if (done_a) nd++;
        end
        n_checks++;
        if (nv != FL || nd != 1) begin
            n_fail++; $display("FAIL midrst_fresh got valid=%0d done=%0d exp %0d 1", nv, nd, FL);
        end
    endtask

    task automatic test_max_frames;
        int nv = 0, nd = 0, last = 0, done_c = 0;
        bit eb;
        send_a(4'b1001, 8'd255);
        for (int c = 1; c <= 255 * FL + 10; c++) begin
            if (c > 1) @(negedge clk);
            if (dv_a) begin
                nv++;
                last = c;
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++; $display("FAIL max_extra_bit cycle %0d", c);
                end else begin
                    eb = qa.pop_front();
                    if (dout_a !== eb) begin
                        n_fail++; $display("FAIL max_bit cycle %0d got %b exp %b", c, dout_a, eb);
                    end
                end
            end
            if (done_a) begin nd++; done_c = c; end
        end
        n_checks++;
        if (nv != 255 * FL || last != 255 * FL || nd != 1 || done_c != 255 * FL + 1) begin
            n_fail++; $display("FAIL max_frames got valid=%0d last=%0d done=%0d at %0d exp %0d %0d 1 %0d",
                               nv, last, nd, done_c, 255 * FL, 255 * FL, 255 * FL + 1);
        end
    endtask

`ifdef SEQ_PATTERN_TX_PARITY_EN
    task automatic test_parity;
        logic [4:0] exp_a;
        logic [4:0] exp_b;
        exp_a = 5'b10111;
        exp_b = 5'b10010;
        send_a(4'b1011, 8'd1);
        for (int i = 4; i >= 0; i--) begin
            if (i < 4) @(negedge clk);
            void'(qa.pop_front());
            n_checks++;
            if (dv_a !== 1'b1 || dout_a !== exp_a[i]) begin
                n_fail++; $display("FAIL parity_1011 bit %0d got dv=%b dout=%b exp 1 %b", i, dv_a, dout_a, exp_a[i]);
            end
        end
        repeat (3) @(negedge clk);
        send_a(4'b1001, 8'd1);
        for (int i = 4; i >= 0; i--) begin
            if (i < 4) @(negedge clk);
            void'(qa.pop_front());
            n_checks++;
            if (dv_a !== 1'b1 || dout_a !== exp_b[i]) begin
                n_fail++; $display("FAIL parity_1001 bit %0d got dv=%b dout=%b exp 1 %b", i, dv_a, dout_a, exp_b[i]);
            end
        end
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_default_gap();
        test_rst_and_valid();
        test_midframe_reset();
        test_max_frames();
`ifdef SEQ_PATTERN_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
